capi_res_arb: RTL and testbench
===============================

// Module: capi_res_arb
// PURPOSE
//  Round-robin arbiter that shares one sequential resource-ID pool among num_req requesters.
//  - Upstream pool side: o_pool_r pops an ID when the pool presents it (valid/id/ready).
//  - Grant side: the popped ID goes to the winning requester.
//  - Caps the outstanding IDs per requester.
//  - Funnels requester releases back to the pool's single free port.
//  - Sits between the pool and the command engines of the CAPI command path.
// PARAMETERS
//  num_req   4   number of requesters (>=2)
//  id_width  4   resource ID width; pool holds 2**id_width IDs
//  max_out   8   max IDs outstanding per requester (1..2**id_width)
// PORTS
//  clk         in   1             clock; all state on rising edge
//  reset       in   1             asynchronous, active-high reset
//  i_req       in   num_req       level request per requester; bit 0 = requester 0
//  o_gnt_v     out  num_req       one-hot grant pulse, one cycle
//  o_gnt_id    out  id_width      ID for the asserted o_gnt_v bit
//  i_pool_v    in   1             pool has an ID available
//  i_pool_id   in   id_width      ID offered by the pool
//  o_pool_r    out  1             pop pool ID this cycle
//  i_rel_v     in   1             release strobe (one release per cycle, system-wide)
//  i_rel_id    in   id_width      ID being released
//  i_rel_req   in   clog2(num_req) requester performing the release
//  o_free_v    out  1             free strobe to the pool
//  o_free_id   out  id_width      ID to the pool free port
//  o_rel_err   out  1             one-cycle pulse on an illegal release
// BEHAVIOUR
//  - Reset: all outputs 0; counters 0; rr pointer 0; owner table 0.
//  - Eligibility and grant:
//    - elig[i] = i_req[i] & (cnt[i] < max_out).
//    - o_pool_r = i_pool_v & |elig (combinational, same cycle).
//    - Winner = first elig at or after the rr pointer, wrapping from num_req-1 to 0.
//  - Grant latency: 1 cycle. On a pop cycle, o_gnt_v[win] and o_gnt_id = i_pool_id are registered.
//    - Next cycle: o_gnt_v is 0 unless a new pop occurs.
//    - Back-to-back grants (one per cycle) are legal.
//  - RR pointer: becomes (win+1) mod num_req on a pop only; unchanged otherwise.
//  - A requester that holds i_req high keeps competing; it may win again after the others.
//  - Counter cnt[i] (width clog2(max_out+1)):
//    - +1 on the pop cycle for the winner; -1 on a release by i.
//    - Same-cycle pop and release for the same i: unchanged.
//    - At max_out the requester is ineligible; it becomes eligible the cycle after its counter drops.
//  - Release:
//    - o_free_v/o_free_id are registered copies of i_rel_v/i_rel_id (1-cycle latency).
//    - The ID is always forwarded, even on error, so the pool never leaks.
//  - Release with cnt[i_rel_req]==0:
//    - Counter saturates at 0 (no decrement).
//    - o_rel_err pulses the next cycle.
//  - Pool empty (i_pool_v=0): no pop, no grant, requests wait; the pointer holds.
//  - Reset mid-operation: in-flight grant/free pulses are dropped; counts clear.
//    - The pool is reset by the same reset, so ownership stays consistent.
// CONFIGURATION
//  RES_ARB_OWNER_CHECK_EN defined:
//    - Owner table of 2**id_width entries x clog2(num_req) bits; entry written on each pop with the winner index.
//    - A release where owner[i_rel_id] != i_rel_req pulses o_rel_err next cycle; the counter is still adjusted per the rules above.
//    - A pop and a release of the same ID cannot coincide.
//  RES_ARB_OWNER_CHECK_EN undefined:
//    - No table; o_rel_err flags only the zero-count case.
// TESTING
//  - Reset, pool valid id=3, i_req=0001 -> o_pool_r=1; next cycle o_gnt_v=0001, o_gnt_id=3; cnt[0]=1.
//  - i_req=1111 held, pool IDs 0,1,2,3,4 offered one per cycle -> grants to req 0,1,2,3,0 with ids 0..4 in order.
//  - max_out=2, only req 1 requesting, pool always valid -> exactly 2 grants, then o_pool_r=0.
//    - Release from req 1 (id 5) -> o_free_v/o_free_id=5 next cycle; a third grant follows.
//  - Same-cycle pop to req 2 and release by req 2 -> cnt[2] unchanged; both o_gnt_v[2] and o_free_v pulse next cycle.
//  - Release id 7 by req 3 with cnt[3]=0 -> o_free_id=7 and o_rel_err=1 next cycle; cnt stays 0.
//  - With RES_ARB_OWNER_CHECK_EN: grant id 9 to req 0, then release id 9 as req 1 (cnt[1]>0) -> o_rel_err=1.
//    - Release id 9 as req 0 -> no error.

Source files
------------

// File: rtl/capi_res_arb.sv
// capi_res_arb: round-robin arbiter sharing one sequential resource-ID pool among num_req requesters.
// Optional macro RES_ARB_OWNER_CHECK_EN adds a per-ID owner table that flags releases by a non-owner.
module capi_res_arb #(
  parameter int num_req  = 4,
  parameter int id_width = 4,
  parameter int max_out  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [num_req-1:0]         i_req,
  output logic [num_req-1:0]         o_gnt_v,
  output logic [id_width-1:0]        o_gnt_id,
  input  logic                       i_pool_v,
  input  logic [id_width-1:0]        i_pool_id,
  output logic                       o_pool_r,
  input  logic                       i_rel_v,
  input  logic [id_width-1:0]        i_rel_id,
  input  logic [$clog2(num_req)-1:0] i_rel_req,
  output logic                       o_free_v,
  output logic [id_width-1:0]        o_free_id,
  output logic                       o_rel_err
);

  localparam int req_w   = $clog2(num_req);
  localparam int cnt_w   = $clog2(max_out + 1);
  localparam int num_ids = 2 ** id_width;

  logic [num_req-1:0]  elig;
  logic                win_found;
  logic [req_w-1:0]    win_idx;
  logic                pop;
  int                  idx;
  logic [req_w-1:0]    rr_q, rr_d;
  logic [cnt_w-1:0]    cnt_q [num_req];
  logic [cnt_w-1:0]    cnt_d [num_req];
  logic                rel_zero;
  logic                owner_err;
  logic [num_req-1:0]  gnt_v_d, gnt_v_q;
  logic [id_width-1:0] gnt_id_q;
  logic                free_v_q;
  logic [id_width-1:0] free_id_q;
  logic                rel_err_q;

  always_comb begin
    for (int i = 0; i < num_req; i++) begin
      elig[i] = i_req[i] && (cnt_q[i] < cnt_w'(max_out));
    end
  end

  // Search starts at the rr pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < num_req; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= num_req) idx = idx - num_req;
      if (!win_found && elig[idx[req_w-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[req_w-1:0];
      end
    end
  end

  assign pop      = i_pool_v && win_found;
  assign o_pool_r = pop && !reset;

  always_comb begin
    gnt_v_d = '0;
    if (pop) gnt_v_d[win_idx] = 1'b1;
    rr_d = rr_q;
    if (pop) rr_d = (win_idx == req_w'(num_req - 1)) ? '0 : win_idx + req_w'(1);
  end

  // A release against a zero count saturates; a simultaneous pop and release cancel out.
  always_comb begin
    rel_zero = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_rel_v && (i_rel_req == req_w'(i)) && (cnt_q[i] == '0)) rel_zero = 1'b1;
      if (pop && (win_idx == req_w'(i))) begin
        if (!(i_rel_v && (i_rel_req == req_w'(i)) && (cnt_q[i] != '0)))
          cnt_d[i] = cnt_q[i] + cnt_w'(1);
      end else if (i_rel_v && (i_rel_req == req_w'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - cnt_w'(1);
      end
    end
  end

`ifdef RES_ARB_OWNER_CHECK_EN
  logic [req_w-1:0] owner_q [num_ids];

  assign owner_err = i_rel_v && (owner_q[i_rel_id] != i_rel_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the owner table is reset like other state so the first releases after reset compare against known owners.
      for (int j = 0; j < num_ids; j++) owner_q[j] <= '0;
    end else if (pop) begin
      owner_q[i_pool_id] <= win_idx;
    end
  end
`else
  assign owner_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      gnt_v_q   <= '0;
      gnt_id_q  <= '0;
      free_v_q  <= 1'b0;
      free_id_q <= '0;
      rel_err_q <= 1'b0;
      for (int i = 0; i < num_req; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rr_q      <= rr_d;
      gnt_v_q   <= gnt_v_d;
      gnt_id_q  <= pop ? i_pool_id : '0;
      free_v_q  <= i_rel_v;
      free_id_q <= i_rel_id;
      rel_err_q <= rel_zero || owner_err;
      for (int i = 0; i < num_req; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_gnt_v   = gnt_v_q;
  assign o_gnt_id  = gnt_id_q;
  assign o_free_v  = free_v_q;
  assign o_free_id = free_id_q;
  assign o_rel_err = rel_err_q;

endmodule

// File: tb/tb_capi_res_arb.sv
// Self-checking bench for capi_res_arb: directed scenarios plus random traffic against a queue/array model.
// Honours RES_ARB_OWNER_CHECK_EN to predict owner-mismatch errors.
module tb_capi_res_arb;

  localparam int NR   = 4;
  localparam int IW   = 4;
  localparam int MO   = 2;
  localparam int NIDS = 16;

`ifdef RES_ARB_OWNER_CHECK_EN
  localparam bit OWNER_EN = 1'b1;
`else
  localparam bit OWNER_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] i_req;
  logic [NR-1:0] o_gnt_v;
  logic [IW-1:0] o_gnt_id;
  logic          i_pool_v;
  logic [IW-1:0] i_pool_id;
  logic          o_pool_r;
  logic          i_rel_v;
  logic [IW-1:0] i_rel_id;
  logic [1:0]    i_rel_req;
  logic          o_free_v;
  logic [IW-1:0] o_free_id;
  logic          o_rel_err;

  int   errors = 0;
  int   checks = 0;
  int   m_cnt [NR];
  int   m_rr;
  int   m_owner [NIDS];
  logic seen_pool_r;

  capi_res_arb #(.num_req(NR), .id_width(IW), .max_out(MO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .o_gnt_v(o_gnt_v), .o_gnt_id(o_gnt_id),
    .i_pool_v(i_pool_v), .i_pool_id(i_pool_id), .o_pool_r(o_pool_r),
    .i_rel_v(i_rel_v), .i_rel_id(i_rel_id), .i_rel_req(i_rel_req),
    .o_free_v(o_free_v), .o_free_id(o_free_id), .o_rel_err(o_rel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    for (int j = 0; j < NIDS; j++) m_owner[j] = 0;
    m_rr = 0;
  endtask

  // One cycle: apply inputs at negedge, predict from the model, compare pool_r then the registered outputs.
  task automatic step(input logic [NR-1:0] req, input logic pv, input logic [IW-1:0] pid,
                      input logic rv, input logic [IW-1:0] rid, input logic [1:0] rreq);
    int            w;
    bit            any;
    bit            exp_pop;
    bit            exp_err;
    bit            do_dec;
    logic [NR-1:0] exp_gnt;
    @(negedge clk);
    i_req = req; i_pool_v = pv; i_pool_id = pid;
    i_rel_v = rv; i_rel_id = rid; i_rel_req = rreq;
    #1;
    any = 1'b0; w = 0;
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (m_rr + k) % NR;
      if (!any && req[c] && m_cnt[c] < MO) begin any = 1'b1; w = c; end
    end
    exp_pop = pv && any;
    exp_gnt = '0;
    if (exp_pop) exp_gnt[w] = 1'b1;
    exp_err = rv && ((m_cnt[rreq] == 0) || (OWNER_EN && m_owner[rid] != int'(rreq)));
    do_dec  = rv && (m_cnt[rreq] > 0);
    seen_pool_r = o_pool_r;
    checks++;
    if (o_pool_r !== exp_pop) begin
      errors++; $display("FAIL pool_r: got %b expected %b", o_pool_r, exp_pop);
    end
    if (exp_pop) begin
      m_cnt[w]++;
      m_rr = (w + 1) % NR;
      m_owner[pid] = w;
    end
    if (do_dec) m_cnt[rreq]--;
    @(posedge clk);
    #1;
    checks++;
    if (o_gnt_v !== exp_gnt) begin
      errors++; $display("FAIL gnt_v: got %b expected %b", o_gnt_v, exp_gnt);
    end
    if (exp_pop) begin
      checks++;
      if (o_gnt_id !== pid) begin
        errors++; $display("FAIL gnt_id: got %0d expected %0d", o_gnt_id, pid);
      end
    end
    checks++;
    if (o_free_v !== rv) begin
      errors++; $display("FAIL free_v: got %b expected %b", o_free_v, rv);
    end
    if (rv) begin
      checks++;
      if (o_free_id !== rid) begin
        errors++; $display("FAIL free_id: got %0d expected %0d", o_free_id, rid);
      end
    end
    checks++;
    if (o_rel_err !== exp_err) begin
      errors++; $display("FAIL rel_err: got %b expected %b", o_rel_err, exp_err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_req = '0; i_pool_v = 1'b0; i_pool_id = '0;
    i_rel_v = 1'b0; i_rel_id = '0; i_rel_req = '0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({o_gnt_v, o_gnt_id, o_pool_r, o_free_v, o_free_id, o_rel_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt_v=%b gnt_id=%0d pool_r=%b free_v=%b free_id=%0d rel_err=%b expected all 0",
               o_gnt_v, o_gnt_id, o_pool_r, o_free_v, o_free_id, o_rel_err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(4'b1111, 1'b1, 4'd3, 1'b0, 4'd0, 2'd0);
    step(4'b1111, 1'b1, 4'd4, 1'b1, 4'd3, 2'd0);
    // Grant and free pulses are in flight here; an asynchronous reset must drop them at once.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({o_gnt_v, o_pool_r, o_free_v, o_rel_err} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got gnt_v=%b pool_r=%b free_v=%b rel_err=%b expected all 0",
               o_gnt_v, o_pool_r, o_free_v, o_rel_err);
    end
    model_reset();
    i_req = '0; i_pool_v = 1'b0; i_rel_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Counts must be clear: requester 0 may take max_out more IDs.
    step(4'b0001, 1'b1, 4'd1, 1'b0, 4'd0, 2'd0);
    step(4'b0001, 1'b1, 4'd2, 1'b0, 4'd0, 2'd0);
    checks++;
    if (seen_pool_r !== 1'b1) begin
      errors++; $display("FAIL reset_cnt_clear: got pool_r=%b expected 1", seen_pool_r);
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    step(4'b0001, 1'b1, 4'd3, 1'b0, 4'd0, 2'd0);
    checks++;
    if (seen_pool_r !== 1'b1 || o_gnt_v !== 4'b0001 || o_gnt_id !== 4'd3) begin
      errors++;
      $display("FAIL single_grant: got pool_r=%b gnt_v=%b id=%0d expected 1 0001 3", seen_pool_r, o_gnt_v, o_gnt_id);
    end
    step(4'b0001, 1'b1, 4'd4, 1'b0, 4'd0, 2'd0);
    step(4'b0001, 1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    checks++;
    if (seen_pool_r !== 1'b0) begin
      errors++; $display("FAIL single_cap: got pool_r=%b expected 0", seen_pool_r);
    end
  endtask

  task automatic test_round_robin();
    int exp_w [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, IW'(k), 1'b0, 4'd0, 2'd0);
      checks++;
      if (o_gnt_v !== (4'b0001 << exp_w[k]) || o_gnt_id !== IW'(k)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got gnt_v=%b id=%0d expected req %0d id %0d", k, o_gnt_v, o_gnt_id, exp_w[k], k);
      end
    end
  endtask

  task automatic test_max_out();
    do_reset();
    step(4'b0010, 1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    step(4'b0010, 1'b1, 4'd6, 1'b0, 4'd0, 2'd0);
    step(4'b0010, 1'b1, 4'd7, 1'b0, 4'd0, 2'd0);
    checks++;
    if (seen_pool_r !== 1'b0) begin
      errors++; $display("FAIL max_out_block: got pool_r=%b expected 0", seen_pool_r);
    end
    step(4'b0010, 1'b1, 4'd7, 1'b1, 4'd5, 2'd1);
    checks++;
    if (o_free_v !== 1'b1 || o_free_id !== 4'd5 || o_rel_err !== 1'b0) begin
      errors++;
      $display("FAIL max_out_release: got free_v=%b id=%0d err=%b expected 1 5 0", o_free_v, o_free_id, o_rel_err);
    end
    step(4'b0010, 1'b1, 4'd7, 1'b0, 4'd0, 2'd0);
    checks++;
    if (o_gnt_v !== 4'b0010 || o_gnt_id !== 4'd7) begin
      errors++; $display("FAIL max_out_regrant: got gnt_v=%b id=%0d expected 0010 7", o_gnt_v, o_gnt_id);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(4'b0100, 1'b1, 4'd2, 1'b0, 4'd0, 2'd0);
    step(4'b0100, 1'b1, 4'd3, 1'b1, 4'd2, 2'd2);
    checks++;
    if (o_gnt_v !== 4'b0100 || o_free_v !== 1'b1 || o_free_id !== 4'd2) begin
      errors++;
      $display("FAIL same_cycle: got gnt_v=%b free_v=%b free_id=%0d expected 0100 1 2", o_gnt_v, o_free_v, o_free_id);
    end
    step(4'b0100, 1'b1, 4'd4, 1'b0, 4'd0, 2'd0);
    step(4'b0100, 1'b1, 4'd5, 1'b0, 4'd0, 2'd0);
    checks++;
    if (seen_pool_r !== 1'b0) begin
      errors++; $display("FAIL same_cycle_cnt: got pool_r=%b expected 0", seen_pool_r);
    end
  endtask

  task automatic test_zero_release();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(4'b0000, 1'b0, 4'd0, 1'b1, 4'd7, 2'd3);
      checks++;
      if (o_free_v !== 1'b1 || o_free_id !== 4'd7 || o_rel_err !== 1'b1) begin
        errors++;
        $display("FAIL zero_release[%0d]: got free_v=%b id=%0d err=%b expected 1 7 1", k, o_free_v, o_free_id, o_rel_err);
      end
    end
  endtask

  task automatic test_owner();
    do_reset();
    step(4'b0001, 1'b1, 4'd9, 1'b0, 4'd0, 2'd0);
    step(4'b0010, 1'b1, 4'd4, 1'b0, 4'd0, 2'd0);
    step(4'b0000, 1'b0, 4'd0, 1'b1, 4'd9, 2'd1);
    checks++;
`ifdef RES_ARB_OWNER_CHECK_EN
    if (o_rel_err !== 1'b1) begin
      errors++; $display("FAIL owner_wrong: got rel_err=%b expected 1", o_rel_err);
    end
`else
    if (o_rel_err !== 1'b0) begin
      errors++; $display("FAIL owner_wrong: got rel_err=%b expected 0", o_rel_err);
    end
`endif
    step(4'b0000, 1'b0, 4'd0, 1'b1, 4'd9, 2'd0);
    checks++;
    if (o_rel_err !== 1'b0) begin
      errors++; $display("FAIL owner_right: got rel_err=%b expected 0", o_rel_err);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] req;
    logic          pv, rv;
    logic [IW-1:0] pid, rid;
    logic [1:0]    rreq;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req  = NR'($urandom_range(0, 15));
      pv   = ($urandom_range(0, 3) != 0);
      pid  = IW'($urandom_range(0, 15));
      rv   = ($urandom_range(0, 9) < 4);
      rid  = IW'($urandom_range(0, 15));
      rreq = 2'($urandom_range(0, 3));
      if (pv && rid == pid) rid = rid + IW'(1);
      step(req, pv, pid, rv, rid, rreq);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req = '0; i_pool_v = 1'b0; i_pool_id = '0;
    i_rel_v = 1'b0; i_rel_id = '0; i_rel_req = '0;
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_max_out();
    test_same_cycle();
    test_zero_release();
    test_owner();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
